// File: rtl/mux8x1_arbiter_pkg.sv
// Shared definitions for the mux8x1 round-robin arbiter: requester count,
// FSM encoding and the rotating-priority winner search.
package mux8x1_arbiter_pkg;

   localparam int NREQ = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // First set bit of req scanning upward from ptr with wrap. The scan runs
   // from the farthest offset down, so the nearest hit is the last one written.
   function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] req,
                                          input logic [2:0]      ptr);
      logic [2:0] idx;
      rr_pick = ptr;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = ptr + 3'(i);
         if (req[idx]) rr_pick = idx;
      end
   endfunction

endpackage

// File: rtl/mux8x1.sv
// Eight-input word multiplexer: y is the word selected by sel.
module mux8x1 #(
   parameter int w = 8
) (
   input  logic [2:0]   sel,
   input  logic [w-1:0] d0,
   input  logic [w-1:0] d1,
   input  logic [w-1:0] d2,
   input  logic [w-1:0] d3,
   input  logic [w-1:0] d4,
   input  logic [w-1:0] d5,
   input  logic [w-1:0] d6,
   input  logic [w-1:0] d7,
   output logic [w-1:0] y
);

   // NOTE: every sel value has an arm, so y is assigned on every path and no latch is inferred.
   always_comb begin
      case (sel)
         3'd0: y = d0;
         3'd1: y = d1;
         3'd2: y = d2;
         3'd3: y = d3;
         3'd4: y = d4;
         3'd5: y = d5;
         3'd6: y = d6;
         3'd7: y = d7;
      endcase
   end

endmodule

// File: rtl/mux8x1_arbiter.sv
// Round-robin arbiter that grants one of eight requesters for up to MAXBURST
// beats and streams its word to a single valid/ready consumer.
module mux8x1_arbiter
   import mux8x1_arbiter_pkg::*;
#(
   parameter int w        = 8,
   parameter int MAXBURST = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic [w-1:0]    data0,
   input  logic [w-1:0]    data1,
   input  logic [w-1:0]    data2,
   input  logic [w-1:0]    data3,
   input  logic [w-1:0]    data4,
   input  logic [w-1:0]    data5,
   input  logic [w-1:0]    data6,
   input  logic [w-1:0]    data7,
   output logic [NREQ-1:0] grant,
   output logic [2:0]      ctrl,
   output logic [w-1:0]    f,
   output logic            valid,
   input  logic            ready
);

   localparam int            CW   = $clog2(MAXBURST + 1);
   localparam logic [CW-1:0] LAST = CW'(MAXBURST - 1);

   state_t        state;
   logic [2:0]    ptr;
   logic [CW-1:0] cnt;
   logic [2:0]    winner;

   always_comb begin
      winner = rr_pick(req, ptr);
      valid  = (state == GRANT) && req[ctrl];
   end

   // NOTE: all state here is registered with <= so every branch sees the pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= '0;
         ctrl  <= '0;
         grant <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  ctrl  <= winner;
                  grant <= NREQ'(1) << winner;
                  cnt   <= '0;
                  state <= GRANT;
               end else begin
                  grant <= '0;
               end
            end
            GRANT: begin
               // A withdraw ends the grant without a transfer, even on the last beat.
               if (!req[ctrl] || (ready && cnt == LAST)) begin
                  state <= IDLE;
                  grant <= '0;
                  ptr   <= ctrl + 3'd1;
               end else if (ready) begin
                  cnt <= cnt + CW'(1);
               end
            end
         endcase
      end
   end

   mux8x1 #(.w(w)) u_mux (
      .sel (ctrl),
      .d0  (data0),
      .d1  (data1),
      .d2  (data2),
      .d3  (data3),
      .d4  (data4),
      .d5  (data5),
      .d6  (data6),
      .d7  (data7),
      .y   (f)
   );

endmodule

// File: tb/tb_mux8x1_arbiter.sv
// Scoreboard bench for mux8x1_arbiter: stimulus queues expected beats, a
// negedge monitor pops and compares every accepted beat.
module tb_mux8x1_arbiter;

   localparam int W  = 8;
   localparam int MB = 4;

   typedef struct packed {
      logic [2:0] idx;
      logic [7:0] data;
   } beat_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   req;
   logic [W-1:0] d [8];
   logic [7:0]   grant;
   logic [2:0]   ctrl;
   logic [W-1:0] f;
   logic         valid;
   logic         ready;

   beat_t exp_q[$];
   int    errors = 0;
   int    checks = 0;

   always #5 clk = ~clk;

   mux8x1_arbiter #(.w(W), .MAXBURST(MB)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .data0 (d[0]),
      .data1 (d[1]),
      .data2 (d[2]),
      .data3 (d[3]),
      .data4 (d[4]),
      .data5 (d[5]),
      .data6 (d[6]),
      .data7 (d[7]),
      .grant (grant),
      .ctrl  (ctrl),
      .f     (f),
      .valid (valid),
      .ready (ready)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered in IDLE with req set so that idx wins the next arbitration.
   task automatic grant_burst(input int idx, input logic [7:0] val);
      for (int b = 0; b < MB; b++) exp_q.push_back(beat_t'{idx: 3'(idx), data: val});
      tick();
      @(negedge clk);
      check("grant_onehot", grant, 32'h1 << idx);
      check("grant_ctrl", ctrl, idx);
      repeat (MB) tick();
      @(negedge clk);
      check("bubble_grant", grant, 0);
      check("bubble_valid", valid, 0);
   endtask

   // Monitor: every accepted beat outside reset must match the queue head.
   always @(negedge clk) begin
      if (!rst && valid && ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL beat_unexpected: got ctrl=%0d f=%0h, expected no beat (t=%0t)", ctrl, f, $time);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            check("beat_ctrl", ctrl, e.idx);
            check("beat_data", f, e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst   = 1'b1;
      req   = 8'h00;
      ready = 1'b1;
      for (int i = 0; i < 8; i++) d[i] = 8'h80 >> i;

      // Reset then idle
      repeat (2) tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_grant", grant, 0);
      check("rst_ctrl", ctrl, 0);
      check("rst_valid", valid, 0);
      check("rst_f", f, 8'h80);

      // Single requester: full burst, bubble, regrant, then withdraw
      req = 8'h08;
      grant_burst(3, 8'h10);
      exp_q.push_back(beat_t'{idx: 3'd3, data: 8'h10});
      tick();
      @(negedge clk);
      check("regrant_grant", grant, 8'h08);
      check("regrant_ctrl", ctrl, 3);
      tick();
      req = 8'h00;
      @(negedge clk);
      check("withdraw_valid", valid, 0);
      tick();
      @(negedge clk);
      check("withdraw_idle", grant, 0);

      // Round robin from ptr 0 over all requesters, wrapping back to 0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = 8'hFF;
      for (int k = 0; k < 9; k++) grant_burst(k % 8, 8'h80 >> (k % 8));

      // Wrap and skip: grant 5 leaves ptr at 6, then 0 and 1 win in turn
      req = 8'h20;
      grant_burst(5, 8'h04);
      req = 8'h03;
      grant_burst(0, 8'h80);
      grant_burst(1, 8'h40);
      req = 8'h00;

      // Backpressure mid-burst, then withdraw on what would be the last beat
      req = 8'h04;
      for (int b = 0; b < 3; b++) exp_q.push_back(beat_t'{idx: 3'd2, data: 8'h20});
      repeat (3) tick();
      ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         check("stall_f", f, 8'h20);
         check("stall_valid", valid, 1);
         check("stall_grant", grant, 8'h04);
         tick();
      end
      ready = 1'b1;
      tick();
      req = 8'h00;
      @(negedge clk);
      check("late_withdraw_valid", valid, 0);
      check("late_withdraw_grant", grant, 8'h04);
      tick();
      @(negedge clk);
      check("late_withdraw_idle", grant, 0);

      // Reset after two beats of a burst; ptr returns to 0 so requester 0 wins
      req = 8'h81;
      for (int b = 0; b < 2; b++) exp_q.push_back(beat_t'{idx: 3'd7, data: 8'h01});
      tick();
      @(negedge clk);
      check("mid_grant", grant, 8'h80);
      check("mid_ctrl", ctrl, 7);
      repeat (2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("midrst_grant", grant, 0);
      check("midrst_ctrl", ctrl, 0);
      check("midrst_valid", valid, 0);
      check("midrst_f", f, 8'h80);
      exp_q.push_back(beat_t'{idx: 3'd0, data: 8'h80});
      tick();
      @(negedge clk);
      check("postrst_grant", grant, 8'h01);
      check("postrst_ctrl", ctrl, 0);
      tick();
      req = 8'h00;
      tick();
      @(negedge clk);
      check("final_idle", grant, 0);

      check("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
